// File: rtl/instr_fetch.sv
// instr_fetch: prefetching instruction fetch unit with an in-order response buffer.
// Define IFU_ALIGN_CHECK_EN to flag misaligned redirect targets (sticky fetch_misalign) and halt fetching.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ir_valid,
    output logic [31:0] ir_instr,
    output logic [31:0] ir_pc,
    input  logic        ir_ready,
    output logic        fetch_misalign
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [31:0]   pc, resp_pc, target;
    logic [31:0]   buf_instr [DEPTH];
    logic [31:0]   buf_pc [DEPTH];
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count, outstanding, drop;
    logic [CW:0]   credit_used;
    logic          misalign_hit, grant, resp, push, pop;
`ifdef IFU_ALIGN_CHECK_EN
    assign target       = redirect_pc;
    assign misalign_hit = redirect & (redirect_pc[1:0] != 2'b00);
`else
    logic unused_lsbs;
    assign unused_lsbs  = ^redirect_pc[1:0];
    assign target       = {redirect_pc[31:2], 2'b00};
    assign misalign_hit = 1'b0;
`endif
    // Stale in-flight fetches still hold credit, so the buffer can never overflow.
    assign credit_used = {1'b0, count} + {1'b0, outstanding};
    assign mem_req     = !rst && !redirect && !fetch_misalign && (credit_used < (CW+1)'(DEPTH));
    assign mem_addr    = pc;
    assign grant       = mem_req & mem_gnt;
    assign resp        = mem_rvalid & (outstanding != '0);
    assign push        = resp & !redirect & (drop == '0);
    assign pop         = ir_valid & ir_ready & !redirect;
    assign ir_valid    = count != '0;
    assign ir_instr    = ir_valid ? buf_instr[head] : '0;
    assign ir_pc       = ir_valid ? buf_pc[head] : '0;
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[tail] <= mem_rdata;
            buf_pc[tail]    <= resp_pc;
        end
    end
    // resp_pc tracks the address of the next response that will be kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc             <= RESET_PC;
            resp_pc        <= RESET_PC;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            outstanding    <= '0;
            drop           <= '0;
            fetch_misalign <= 1'b0;
        end else begin
            outstanding <= outstanding + CW'(grant) - CW'(resp);
            if (redirect) begin
                pc             <= target;
                resp_pc        <= target;
                head           <= '0;
                tail           <= '0;
                count          <= '0;
                drop           <= outstanding - CW'(resp);
                fetch_misalign <= fetch_misalign | misalign_hit;
            end else begin
                if (grant) pc <= pc + 32'd4;
                if (push) begin
                    tail    <= tail + 1'b1;
                    resp_pc <= resp_pc + 32'd4;
                end
                if (pop) head <= head + 1'b1;
                count <= count + CW'(push) - CW'(pop);
                if (resp && drop != '0) drop <= drop - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized bench for instr_fetch against a queue-based model of the fetch stream.
module tb_instr_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;
    logic        clk = 1'b0, rst = 1'b1;
    logic        mem_req, mem_gnt, mem_rvalid, redirect, ir_valid, ir_ready, fetch_misalign;
    logic [31:0] mem_addr, mem_rdata, redirect_pc, ir_instr, ir_pc;
    always #5 clk = ~clk;
    instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
        .ir_valid(ir_valid), .ir_instr(ir_instr), .ir_pc(ir_pc), .ir_ready(ir_ready),
        .fetch_misalign(fetch_misalign)
    );
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    typedef struct { logic [31:0] addr; bit stale; } fl_t;
    ent_t        bq[$];
    fl_t         fq[$];
    logic [31:0] exp_pc;
    bit          halted, exp_req, found;
    int          n_chk = 0, n_fail = 0;
    int          p_gnt, p_rv, p_rdy, p_redir;
    function automatic logic [31:0] instr_of(logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask
    task automatic drive_rand();
        redirect    = $urandom_range(99) < p_redir;
        redirect_pc = $urandom & 32'h0000_FFFF;
`ifdef IFU_ALIGN_CHECK_EN
        redirect_pc[1:0] = 2'b00;
`endif
        if ($urandom_range(7) == 0) redirect_pc = 32'hFFFF_FFF0 | {28'h0, redirect_pc[3:0]};
        mem_gnt  = $urandom_range(99) < p_gnt;
        ir_ready = $urandom_range(99) < p_rdy;
        if (fq.size() > 0) begin
            mem_rvalid = $urandom_range(99) < p_rv;
            mem_rdata  = mem_rvalid ? instr_of(fq[0].addr) : $urandom;
        end else begin
            mem_rvalid = $urandom_range(49) == 0;
            mem_rdata  = $urandom;
        end
    endtask
    task automatic compare();
        exp_req = !rst && !redirect && !halted && (bq.size() + fq.size() < DEPTH);
        chk("mem_req", mem_req, exp_req);
        if (exp_req) chk("mem_addr", mem_addr, exp_pc);
        chk("ir_valid", ir_valid, bq.size() > 0);
        chk("ir_pc", ir_pc, bq.size() > 0 ? bq[0].pc : 32'h0);
        chk("ir_instr", ir_instr, bq.size() > 0 ? bq[0].instr : 32'h0);
        chk("fetch_misalign", fetch_misalign, halted);
    endtask
    task automatic update();
        fl_t r;
        if (!redirect && bq.size() > 0 && ir_ready) void'(bq.pop_front());
        if (mem_rvalid && fq.size() > 0) begin
            r = fq.pop_front();
            if (!redirect && !r.stale) bq.push_back('{r.addr, instr_of(r.addr)});
        end
        if (redirect) begin
            bq.delete();
            foreach (fq[i]) fq[i].stale = 1'b1;
`ifdef IFU_ALIGN_CHECK_EN
            exp_pc = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) halted = 1'b1;
`else
            exp_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
        end
        if (exp_req && mem_gnt) begin
            fq.push_back('{exp_pc, 1'b0});
            exp_pc += 32'd4;
        end
    endtask
    task automatic settle();
        #1;
        compare();
    endtask
    task automatic advance();
        update();
        @(negedge clk);
    endtask
    task automatic step();
        drive_rand();
        settle();
        advance();
    endtask
    task automatic force_redirect(logic [31:0] tgt);
        drive_rand();
        redirect    = 1'b1;
        redirect_pc = tgt;
    endtask
    task automatic do_reset(int cycles);
        rst = 1'b1;
        {redirect, mem_gnt, mem_rvalid, ir_ready} = 4'b0;
        redirect_pc = '0;
        mem_rdata   = '0;
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_ir_valid", ir_valid, 0);
        chk("rst_ir_instr", ir_instr, 0);
        chk("rst_ir_pc", ir_pc, 0);
        chk("rst_misalign", fetch_misalign, 0);
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        bq.delete();
        fq.delete();
        exp_pc = RESET_PC;
        halted = 1'b0;
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        {redirect, mem_gnt, mem_rvalid, ir_ready} = 4'b0;
        redirect_pc = '0;
        mem_rdata   = '0;
        @(negedge clk);
        do_reset(3);
        // Full-rate streaming from reset.
        p_gnt = 100; p_rv = 100; p_rdy = 100; p_redir = 0;
        for (int c = 0; c < 12; c++) begin
            drive_rand();
            settle();
            chk("stream_addr", mem_addr, 32'(c * 4));
            if (c >= 2) begin
                chk("stream_valid", ir_valid, 1);
                chk("stream_pc", ir_pc, 32'((c - 2) * 4));
            end
            advance();
        end
        // Consumer stalls: buffer fills to DEPTH and fetching stops.
        p_rdy = 0;
        for (int c = 0; c < 10; c++) step();
        chk("stall_depth", bq.size(), DEPTH);
        p_rdy = 100;
        for (int d = 0; d < 4; d++) begin
            drive_rand();
            settle();
            if (d == 0) chk("stall_mem_req", mem_req, 0);
            chk("drain_pc", ir_pc, 32'd40 + 32'(4 * d));
            advance();
        end
        for (int c = 0; c < 4; c++) step();
        // Redirect while popping and receiving a response.
        force_redirect(32'h0000_0200);
        if (fq.size() > 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = instr_of(fq[0].addr);
        end
        settle();
        advance();
        p_rv = 0;
        drive_rand();
        settle();
        chk("flush_valid", ir_valid, 0);
        chk("redir_req", mem_req, 1);
        chk("redir_addr", mem_addr, 32'h0000_0200);
        advance();
        step();
        chk("two_outstanding", fq.size(), 2);
        // Redirect with two fetches in flight; both must be dropped.
        force_redirect(32'h0000_0100);
        mem_rvalid = 1'b0;
        settle();
        advance();
        p_rv  = 100;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            drive_rand();
            settle();
            if (ir_valid) begin
                found = 1'b1;
                chk("redir_first_pc", ir_pc, 32'h0000_0100);
            end
            advance();
        end
        chk("redir_seen", found, 1);
        // Address wrap at the top of the address space.
        force_redirect(32'hFFFF_FFF8);
        settle();
        advance();
        for (int c = 0; c < 4; c++) begin
            drive_rand();
            settle();
            chk("wrap_addr", mem_addr, 32'hFFFF_FFF8 + 32'(4 * c));
            advance();
        end
        // Reset mid-burst, then a stray response that must be ignored.
        do_reset(2);
        drive_rand();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        settle();
        chk("post_rst_req", mem_req, 1);
        chk("post_rst_addr", mem_addr, RESET_PC);
        advance();
        for (int c = 0; c < 6; c++) step();
        // Misaligned redirect target.
        force_redirect(32'h0000_0102);
        settle();
        advance();
`ifdef IFU_ALIGN_CHECK_EN
        for (int c = 0; c < 10; c++) begin
            drive_rand();
            settle();
            chk("misalign_flag", fetch_misalign, 1);
            chk("misalign_halt", mem_req, 0);
            advance();
        end
        do_reset(2);
`else
        drive_rand();
        settle();
        chk("align_addr", mem_addr, 32'h0000_0100);
        chk("align_flag", fetch_misalign, 0);
        advance();
`endif
        // Randomized phases.
        for (int ph = 0; ph < 8; ph++) begin
            p_gnt   = $urandom_range(100, 20);
            p_rv    = $urandom_range(100, 20);
            p_rdy   = $urandom_range(100, 0);
            p_redir = $urandom_range(10, 0);
            for (int c = 0; c < 500; c++) step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
